keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Front-end for the 4x4 matrix keypad. Drives the column lines one-hot, samples the row lines (fila) and debounces the press.
- Emits one registered key code with a single-cycle valid strobe per press.
- Sits directly upstream of the digit-entry/display logic in Top, which consumes key_code/key_valid to build the 3-digit setpoint.

Parameters:
- CLK_DIV, 50000, clk cycles per scan tick (column dwell time); 1 ms at 50 MHz; legal range >= 2.
- DEBOUNCE_CNT, 8, consecutive scan ticks a press or release must be stable before it is accepted; legal range >= 1.
- REPEAT_TICKS, 500, ticks between repeated strobes while a key is held; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- fila  in  4  keypad row lines, active-high, asynchronous to clk.
- col  out  4  keypad column drive, one-hot, active-high.
- key_code  out  4  code of the last accepted key; held until the next accept.
- key_valid  out  1  one-cycle strobe: key_code is new this cycle.
- key_held  out  1  high while the accepted key is still pressed.

Behaviour:
- Reset (async, active-high):
  - col=4'b0001, key_code=0, key_valid=0, key_held=0.
  - Tick counter=0, debounce counter=0, state=SCAN.
  - Synchronizer flops cleared.
- Input synchronization:
  - fila passes through a 2-flop synchronizer (fs). All decisions use fs only.
- Tick generation:
  - tick is a 1-cycle pulse every CLK_DIV clocks.
  - The counter free-runs in every state.
- Key map, row r / col c (index 0 = LSB):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *,0,#,D
  - Codes: digits = value, A..D = 0xA..0xD, * = 0xE, # = 0xF.
- FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - On tick with fs==0: rotate col left (0001->0010->0100->1000->0001).
  - On tick with fs!=0: keep col, capture row = lowest set bit of fs (one-hot), clear debounce counter, go to DEBOUNCE.
- DEBOUNCE:
  - On each tick, compare fs with the captured row.
  - Match: counter+1.
  - Mismatch: go to SCAN; col rotates on the next tick.
  - When the counter reaches DEBOUNCE_CNT: key_code=map(row,col), key_valid=1 for exactly one clk, key_held=1, go to HOLD.
- HOLD:
  - col stays frozen.
  - On tick with fs==0: counter cleared, go to RELEASE.
  - No repeat strobe is issued (default build).
- RELEASE:
  - On tick with fs!=0: go back to HOLD (bounce).
  - On DEBOUNCE_CNT consecutive ticks with fs==0: key_held=0, go to SCAN.
- Multiple keys:
  - Only the lowest row in the active column is accepted.
  - Other keys are ignored until the full release.
  - A second key in the same column keeps HOLD alive.
- Latency:
  - key_valid rises on the clk edge after tick number DEBOUNCE_CNT following the capture tick.
  - Bounded by (DEBOUNCE_CNT+4)*CLK_DIV+3 clocks from a stable press.
- key_code never changes except on a key_valid cycle.
- Reset mid-press: outputs return to reset values immediately. A key still held after reset is re-detected and strobed once.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in HOLD, after REPEAT_TICKS ticks of continuous press, key_valid pulses again with the same key_code. The pulse repeats every REPEAT_TICKS ticks until release starts. The repeat counter clears on entering HOLD and on RELEASE->HOLD.
- Undefined: exactly one strobe per press; REPEAT_TICKS is unused.

Test Plan (CLK_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5):
- Reset: assert reset mid-tick -> col=0001, key_valid=0, key_code=0, key_held=0 immediately (async). After release, col steps 0001->0010->0100->1000->0001, each held 4 clks.
- Clean press: when col==0010, hold fila=0001 for 40 clks -> exactly one key_valid pulse with key_code=2. key_held=1 until fila=0 for 3 ticks, then key_held=0 and scanning resumes.
- Bounce: when col==0001, apply fila=0100 for 2 ticks, then 0, then 0100 again -> no strobe during the bounce. One strobe with key_code=7 after 3 stable ticks.
- Release glitch: in HOLD on key 5, apply fila=0 for 1 tick then 0010 again -> key_held stays 1, no second strobe.
- Two keys in the same column: fila=0110 at col==0100 -> key_code=6 (row1 wins), single strobe.
- With KEYPAD_AUTOREPEAT_EN: hold key 8 (col==0010, fila=0100) for 20 ticks -> strobes at accept, +5 ticks, +10 ticks, +15 ticks, all key_code=8. Without the macro: one strobe.

Source files
------------

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: 4x4 matrix keypad front-end.
// Drives the columns one-hot, synchronizes the row lines, and debounces both
// press and release. Each accepted press produces one registered key code
// with a single-cycle valid strobe.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   fila[3:0]  row lines, active-high, asynchronous to clk
//   col[3:0]   column drive, one-hot, active-high
//   key_code   code of the last accepted key, held until the next accept
//   key_valid  one-cycle strobe, key_code is new this cycle
//   key_held   high while the accepted key is still pressed
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe the held key
// every REPEAT_TICKS scan ticks while it stays pressed.
module keypad_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CNT);
  localparam logic [RW-1:0] REP_DONE  = RW'(REPEAT_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [3:0]    sync1_q, fs_q;
  logic [3:0]    fs_low;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [3:0]    map_code;

  function automatic logic [1:0] enc4(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick     = (tick_cnt_q == TICK_LAST);
  // Isolate the lowest asserted row so the lowest key in a column wins.
  assign fs_low   = fs_q & (~fs_q + 4'd1);
  assign deb_inc  = deb_q + DW'(1);
  assign rep_inc  = rep_q + RW'(1);
  assign map_code = key_map(enc4(row_q), enc4(col_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      fs_q       <= '0;
      state_q    <= SCAN;
      col_q      <= 4'b0001;
      row_q      <= '0;
      deb_q      <= '0;
      rep_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      sync1_q    <= fila;
      fs_q       <= sync1_q;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      deb_q      <= deb_d;
      rep_q      <= rep_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (fs_q == '0) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            row_d   = fs_low;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (fs_low != row_q) begin
            state_d = SCAN;
          end else if (deb_inc == DEB_DONE) begin
            code_d  = map_code;
            valid_d = 1'b1;
            held_d  = 1'b1;
            rep_d   = '0;
            state_d = HOLD;
          end else begin
            deb_d = deb_inc;
          end
        end
        HOLD: begin
          if (fs_q == '0) begin
            deb_d   = '0;
            state_d = RELEASE;
          end else if (AUTOREPEAT) begin
            if (rep_inc == REP_DONE) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_inc;
            end
          end
        end
        default: begin // RELEASE
          if (fs_q != '0) begin
            rep_d   = '0;
            state_d = HOLD;
          end else if (deb_inc == DEB_DONE) begin
            held_d  = 1'b0;
            state_d = SCAN;
          end else begin
            deb_d = deb_inc;
          end
        end
      endcase
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
